// File: rtl/mul_acc.sv
// mul_acc: sequential unsigned multiply-accumulate, D = q*d + r.
// One shift-and-add iteration per clock, fixed WIDTH-cycle latency,
// start/busy/done handshake.
// Optional feature: define MUL_ACC_CHECK_EN to build the remainder check
// (err = 1 when the captured r >= d); otherwise err is tied to 0.
module mul_acc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     q,
    input  logic [WIDTH-1:0]     d,
    input  logic [WIDTH-1:0]     r,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   D,
    output logic                 err
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   res_q, res_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   sum;
`ifdef MUL_ACC_CHECK_EN
    logic            chk_q, chk_d;
    logic            err_q, err_d;
`endif

    // State and datapath registers, cleared by async reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MUL_ACC_CHECK_EN
            chk_q    <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MUL_ACC_CHECK_EN
            chk_q    <= chk_d;
            err_q    <= err_d;
`endif
        end
    end

    // Next-state, shift-and-add iteration and registered output values
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        sum      = acc_q + mcand_q;
`ifdef MUL_ACC_CHECK_EN
        chk_d    = chk_q;
        err_d    = err_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    acc_d    = DW'(r);
                    mcand_d  = DW'(d);
                    mplier_d = q;
                    cnt_d    = CW'(WIDTH);
`ifdef MUL_ACC_CHECK_EN
                    // r >= d also covers d == 0
                    chk_d    = (r >= d);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = sum;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    res_d   = acc_d;
`ifdef MUL_ACC_CHECK_EN
                    err_d   = chk_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = res_q;
`ifdef MUL_ACC_CHECK_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_mul_acc.sv
// tb_mul_acc: self-checking bench for mul_acc (directed + random runs
// against an arithmetic reference q*d + r).
`timescale 1ns/1ps
module tb_mul_acc;

    localparam int unsigned WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   d;
    logic [WIDTH-1:0]   r;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] D;
    logic               err;

    int checks = 0;
    int errors = 0;
    logic [2*WIDTH-1:0] d_prev;
    logic               mon_en = 1'b0;

    mul_acc #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q     (q),
        .d     (d),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_d(input int unsigned qv, input int unsigned dv, input int unsigned rv);
        return 32'(qv * dv + rv);
    endfunction

    function automatic logic ref_err(input int unsigned dv, input int unsigned rv);
`ifdef MUL_ACC_CHECK_EN
        return (rv >= dv);
`else
        return 1'b0;
`endif
    endfunction

    // busy/done exclusivity and D/err only moving with a done pulse
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy_done_excl", 32'(busy & done), 32'd0);
            if (D !== d_prev) check("d_change_with_done", 32'(done), 32'd1);
        end
        d_prev <= D;
    end

    // Start a run with the given operands; optional mid-run start with other operands
    task automatic do_run(input logic [WIDTH-1:0] qv, input logic [WIDTH-1:0] dv,
                          input logic [WIDTH-1:0] rv, input bit mid, input string tag);
        logic [2*WIDTH-1:0] held;
        int n;
        held  = D;
        q     = qv;
        d     = dv;
        r     = rv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        check({tag, "_busy0"}, 32'(busy), 32'd1);
        check({tag, "_done0"}, 32'(done), 32'd0);
        while (!done && n < 20) begin
            if (mid && n == 3) begin
                q = 8'd1; d = 8'd1; r = 8'd0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!mid) begin
                q = 8'($urandom); d = 8'($urandom); r = 8'($urandom);
            end
            @(posedge clk); #1;
            n++;
            if (!done && n < WIDTH) check({tag, "_hold"}, 32'(D), 32'(held));
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(WIDTH));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_D"}, 32'(D), ref_d(qv, dv, rv));
        check({tag, "_err"}, 32'(err), 32'(ref_err(dv, rv)));
    endtask

    initial begin
        int n;
        logic seen_done;
        rst = 1'b1; start = 1'b0; q = '0; d = '0; r = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_D", 32'(D), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        do_run(8'd7, 8'd2, 8'd1, 1'b0, "basic");
        @(posedge clk); #1;
        check("done_pulse_one", 32'(done), 32'd0);
        check("D_held_idle", 32'(D), 32'd15);

        do_run(8'd0, 8'd2, 8'd0, 1'b0, "q0");
        do_run(8'd255, 8'd255, 8'd254, 1'b0, "max");
        do_run(8'd3, 8'd0, 8'd5, 1'b0, "d0");
        @(posedge clk); #1;

        // second start mid-run ignored, then back-to-back start in done cycle
        do_run(8'd7, 8'd2, 8'd1, 1'b1, "mid");
        do_run(8'd5, 8'd3, 8'd2, 1'b0, "b2b");

        // error-flag cases
        do_run(8'd4, 8'd2, 8'd3, 1'b0, "err_a");
        do_run(8'd4, 8'd3, 8'd2, 1'b0, "err_b");
        do_run(8'd1, 8'd0, 8'd0, 1'b0, "err_c");
        do_run(8'd9, 8'd9, 8'd9, 1'b0, "pre_rst");

        // reset four cycles into a run
        q = 8'd7; d = 8'd2; r = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_D", 32'(D), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("arst_no_done", 32'(seen_done), 32'd0);
        mon_en = 1'b1;
        do_run(8'd12, 8'd11, 8'd10, 1'b0, "post_rst");

        // random back-to-back runs
        for (int k = 0; k < 1000; k++) begin
            do_run(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, "rand");
        end

        n = 0;
        @(posedge clk); #1;
        check("final_done_low", 32'(done), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_acc.md
# mul_acc

Sequential unsigned multiply-accumulate unit computing D = q·d + r, the inverse of the team's restoring divider: it rebuilds a dividend from quotient, divisor and remainder. Used to check division results in the datapath and as a general shift-and-add multiplier with start/done handshake. One iteration per clock, fixed latency, single clock domain.

## Interface
- WIDTH, 8, operand width for q, d and r; result is 2·WIDTH bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- q  input  WIDTH  multiplier (quotient)
- d  input  WIDTH  multiplicand (divisor)
- r  input  WIDTH  addend (remainder)
- busy  output  1  iteration in progress
- done  output  1  one-cycle pulse, D valid
- D  output  2·WIDTH  result, held until next completion
- err  output  1  remainder-check flag, valid with done (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1: latch acc = zero-extended r, mcand = zero-extended d (2·WIDTH bits), mplier = q, cnt = WIDTH; go to RUN.
- RUN, each cycle: if mplier[0], acc = acc + mcand; mcand <<= 1; mplier >>= 1; cnt -= 1. On the iteration with cnt=1, go to DONE and register D = final acc.
- DONE: done=1 for exactly one cycle; next state IDLE, or RUN if start=1 that cycle.
- start while in RUN is ignored; no queueing.
- Operands are captured at the start edge; changes to q/d/r during RUN have no effect.
- Arithmetic: unsigned, all adds at 2·WIDTH bits. Max result (2^WIDTH−1)² + (2^WIDTH−1) = 2^(2·WIDTH) − 2^WIDTH, so no overflow is possible.
- No early termination: latency is fixed regardless of q (q=0 still takes WIDTH cycles).
- d=0 is legal and yields D = r.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, D=0, err=0, internal registers cleared. Reset mid-RUN aborts; no done pulse follows.
- Start accepted at edge k. busy=1 after edges k … k+WIDTH−1 (WIDTH cycles).
- After edge k+WIDTH: busy=0, done=1, D and err hold the new values. After edge k+WIDTH+1: done=0.
- Latency start-edge to done: WIDTH cycles (8 at default). Back-to-back throughput: one result every WIDTH+1 cycles (start asserted during the done cycle).
- D and err change only at the edge that raises done; otherwise stable.
- busy and done are never high together.

## Configuration
- MUL_ACC_CHECK_EN defined: at the completion edge, err = 1 if r ≥ d in the captured operands (includes d=0), meaning the triple is not a legal divider output; D is still computed and driven normally. err holds with D.
- MUL_ACC_CHECK_EN undefined: err is tied to 0 and the comparator is not built; all other behaviour identical.

## Test plan
- Reset, then q=7, d=2, r=1, start one cycle -> busy for 8 cycles, done pulse exactly 8 cycles after the start edge, D=15, err=0.
- q=0, d=2, r=0 -> D=0 after 8 cycles (no early exit); then q=255, d=255, r=254 -> D=65279; then q=3, d=0, r=5 -> D=5.
- Start at q=7,d=2,r=1, then start again mid-RUN with q=1,d=1,r=0 -> second start ignored, D=15; start asserted during the done cycle with q=5,d=3,r=2 -> busy next cycle, D=17 after 8 more cycles.
- Assert rst 4 cycles into a run -> busy, done, D, err go to 0 immediately; no done pulse; next start completes normally.
- With MUL_ACC_CHECK_EN: q=4, d=2, r=3 -> D=11, err=1; q=4, d=3, r=2 -> D=14, err=0; q=1, d=0, r=0 -> D=0, err=1. Without macro: same D values, err=0 throughout.
- Random q/d/r, 1000 runs, back-to-back starts -> D matches q·d+r each done; busy and done never high together.
